// File: rtl/sd_sector_responder.sv
// Storage-side responder for the sd_bus sector protocol: moves 512-byte sectors between controller buffer and image memory.
// Optional build macro SD_RESP_BOUNDS_EN enables the per-request image-size range check.
module sd_sector_responder #(
    parameter int                MEM_AW    = 27,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic              sd_buff_wr,
    input  logic [31:0]       img_size,
    input  logic              img_readonly,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    input  logic              mem_ready
);

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_PUT,
        WR_ADDR,
        WR_FETCH,
        WR_MEM,
        WR_WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  index_q, index_d;
    logic [31:0] lba_q, lba_d;
    logic [7:0]  data_q, data_d;
    logic        oob_q, oob_d;
    logic        range_bad;
    logic        last_byte;

`ifdef SD_RESP_BOUNDS_EN
    // Wide enough that lba*512 + 512 never overflows before comparing to the image size.
    logic [41:0] sector_end;
    assign sector_end = {1'b0, sd_lba, 9'b0} + 42'd512;
    assign range_bad  = sector_end > {10'b0, img_size};
`else
    logic unused_img_size;
    assign unused_img_size = ^img_size;
    assign range_bad       = 1'b0;
`endif

    assign last_byte = (index_q == 9'd511);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            lba_q   <= '0;
            data_q  <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            lba_q   <= lba_d;
            data_q  <= data_d;
            oob_q   <= oob_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        lba_d   = lba_q;
        data_d  = data_q;
        oob_d   = oob_q;
        case (state_q)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d   = sd_lba;
                    index_d = '0;
                    oob_d   = range_bad;
                    state_d = sd_rd ? RD_REQ : WR_ADDR;
                end
            end
            RD_REQ: begin
                if (oob_q) begin
                    data_d  = 8'hFF;
                    state_d = RD_PUT;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    data_d  = mem_din;
                    state_d = RD_PUT;
                end
            end
            RD_PUT: begin
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 9'd1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: begin
                state_d = WR_FETCH;
            end
            WR_FETCH: begin
                data_d = sd_buff_din;
                // Discarded writes still walk every index so the controller sees a normal transfer.
                if (img_readonly || oob_q) begin
                    if (last_byte) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 9'd1;
                        state_d = WR_ADDR;
                    end
                end else begin
                    state_d = WR_MEM;
                end
            end
            WR_MEM: begin
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    if (last_byte) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 9'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sd_ack       = (state_q != IDLE) && (state_q != DONE);
    assign sd_buff_addr = index_q;
    assign sd_buff_dout = data_q;
    assign sd_buff_wr   = (state_q == RD_PUT);
    assign mem_rd       = (state_q == RD_REQ) && !oob_q;
    assign mem_wr       = (state_q == WR_MEM);
    assign mem_dout     = data_q;
    assign mem_addr     = BASE_ADDR + MEM_AW'({lba_q, 9'b0}) + MEM_AW'(index_q);

endmodule

// File: tb/tb_sd_sector_responder.sv
// Self-checking bench for sd_sector_responder: memory/buffer models plus scoreboard queues of expected strobes.
// Test 4 expectations follow SD_RESP_BOUNDS_EN when the bench is built with it.
module tb_sd_sector_responder;

    localparam int MEM_AW = 27;

    logic              clk;
    logic              reset;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din;
    logic              sd_buff_wr;
    logic [31:0]       img_size;
    logic              img_readonly;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem      [0:1048575];
    logic [7:0]  ctrl_buf [0:511];
    logic [63:0] exp_buf_q [$];
    logic [63:0] exp_mr_q  [$];
    logic [63:0] exp_mw_q  [$];

    int buff_wr_cnt = 0;
    int mem_rd_cnt  = 0;
    int mem_wr_cnt  = 0;
    int ack_cnt     = 0;
    int mem_wait    = 0;
    logic [7:0] rd_lat;

    sd_sector_responder #(.MEM_AW(MEM_AW), .BASE_ADDR('0)) dut (
        .clk          (clk),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Memory answers every request with a ready pulse two cycles after the strobe.
    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (reset) begin
            mem_wait = 0;
        end else begin
            if (mem_wait == 1) begin
                mem_ready <= 1'b1;
                mem_din   <= rd_lat;
                mem_wait = 0;
            end
            if (mem_rd) begin
                rd_lat   = mem[mem_addr[19:0]];
                mem_wait = 1;
            end else if (mem_wr) begin
                mem[mem_addr[19:0]] = mem_dout;
                mem_wait = 1;
            end
        end
    end

    always @(posedge clk) sd_buff_din <= ctrl_buf[sd_buff_addr];

    // Every strobe the DUT produces is matched against the head of its expectation queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (sd_ack) ack_cnt++;
        if (sd_buff_wr) begin
            buff_wr_cnt++;
            if (exp_buf_q.size() == 0) checkOutput("unexpected_buff_wr", {55'b0, sd_buff_addr}, 64'hFFFF);
            else begin
                e = exp_buf_q.pop_front();
                checkOutput("buff_wr", {47'b0, sd_buff_addr, sd_buff_dout}, e);
            end
        end
        if (mem_rd) begin
            mem_rd_cnt++;
            if (exp_mr_q.size() == 0) checkOutput("unexpected_mem_rd", {37'b0, mem_addr}, 64'hFFFF_FFFF);
            else begin
                e = exp_mr_q.pop_front();
                checkOutput("mem_rd_addr", {37'b0, mem_addr}, e);
            end
        end
        if (mem_wr) begin
            mem_wr_cnt++;
            if (exp_mw_q.size() == 0) checkOutput("unexpected_mem_wr", {37'b0, mem_addr}, 64'hFFFF_FFFF);
            else begin
                e = exp_mw_q.pop_front();
                checkOutput("mem_wr", {29'b0, mem_addr, mem_dout}, e);
            end
        end
        if (mem_rd || mem_wr) checkOutput("rd_wr_exclusive", {63'b0, mem_rd & mem_wr}, 64'd0);
    end

    task automatic waitAck(input logic level, input int budget, input string tag);
        int n = 0;
        while (sd_ack !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {63'b0, sd_ack}, {63'b0, level});
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] lba, input bit hold);
        @(negedge clk);
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
        waitAck(1'b1, 10, "ack_rise");
        if (!hold) begin
            sd_rd = 1'b0;
            sd_wr = 1'b0;
        end
    endtask

    task automatic pushRead(input logic [31:0] base, input bit oob, input int count, input int rd_count);
        for (int i = 0; i < count; i++)
            exp_buf_q.push_back({47'b0, 9'(i), (oob ? 8'hFF : 8'(i))});
        if (!oob)
            for (int i = 0; i < rd_count; i++) exp_mr_q.push_back(64'(base + 32'(i)));
    endtask

    task automatic checkCounts(input string tag, input int bw0, input int mr0, input int mw0, input int ak0,
                               input int bw, input int mr, input int mw, input int ak);
        checkOutput({tag, "_buff_wr_count"}, 64'(buff_wr_cnt - bw0), 64'(bw));
        checkOutput({tag, "_mem_rd_count"},  64'(mem_rd_cnt - mr0),  64'(mr));
        checkOutput({tag, "_mem_wr_count"},  64'(mem_wr_cnt - mw0),  64'(mw));
        if (ak >= 0) checkOutput({tag, "_ack_cycles"}, 64'(ack_cnt - ak0), 64'(ak));
        checkOutput({tag, "_queues_empty"}, 64'(exp_buf_q.size() + exp_mr_q.size() + exp_mw_q.size()), 64'd0);
    endtask

    initial begin
        int bw0, mr0, mw0, ak0, bad, n;
        for (int a = 0; a < 1048576; a++) mem[a] = 8'(a);
        for (int i = 0; i < 512; i++) ctrl_buf[i] = 8'h00;
        reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
        img_size = '0; img_readonly = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ack",       {63'b0, sd_ack},       64'd0);
        checkOutput("reset_buff_wr",   {63'b0, sd_buff_wr},   64'd0);
        checkOutput("reset_mem_rd",    {63'b0, mem_rd},       64'd0);
        checkOutput("reset_mem_wr",    {63'b0, mem_wr},       64'd0);
        checkOutput("reset_buff_addr", {55'b0, sd_buff_addr}, 64'd0);
        checkOutput("reset_mem_addr",  {37'b0, mem_addr},     64'd0);
        reset = 1'b0;

        $display("[TB] test 1: read lba 2");
        bw0 = buff_wr_cnt; mr0 = mem_rd_cnt; mw0 = mem_wr_cnt; ak0 = ack_cnt;
        pushRead(32'h400, 0, 512, 512);
        applyStimulus(1'b1, 1'b0, 32'd2, 0);
        waitAck(1'b0, 4000, "t1_ack_fall");
        checkCounts("t1", bw0, mr0, mw0, ak0, 512, 512, 0, 2048);

        $display("[TB] test 2: write lba 1");
        for (int i = 0; i < 512; i++) begin
            ctrl_buf[i] = ~8'(i);
            exp_mw_q.push_back({29'b0, 27'(32'h200 + i), ~8'(i)});
        end
        bw0 = buff_wr_cnt; mr0 = mem_rd_cnt; mw0 = mem_wr_cnt; ak0 = ack_cnt;
        applyStimulus(1'b0, 1'b1, 32'd1, 0);
        waitAck(1'b0, 4000, "t2_ack_fall");
        checkCounts("t2", bw0, mr0, mw0, ak0, 0, 0, 512, 2560);
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[32'h200 + i] !== ~8'(i)) bad++;
        checkOutput("t2_mem_contents", 64'(bad), 64'd0);
        checkOutput("t2_mem_below", {56'b0, mem[20'h1FF]}, 64'hFF);

        $display("[TB] test 3: read-only write lba 1");
        img_readonly = 1'b1;
        for (int i = 0; i < 512; i++) ctrl_buf[i] = 8'h5A ^ 8'(i);
        bw0 = buff_wr_cnt; mr0 = mem_rd_cnt; mw0 = mem_wr_cnt; ak0 = ack_cnt;
        applyStimulus(1'b0, 1'b1, 32'd1, 0);
        waitAck(1'b0, 4000, "t3_ack_fall");
        checkCounts("t3", bw0, mr0, mw0, ak0, 0, 0, 0, 1024);
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[32'h200 + i] !== ~8'(i)) bad++;
        checkOutput("t3_mem_unchanged", 64'(bad), 64'd0);
        img_readonly = 1'b0;

        $display("[TB] test 4: image size boundary");
        img_size = 32'h5A000;
        bw0 = buff_wr_cnt; mr0 = mem_rd_cnt; mw0 = mem_wr_cnt; ak0 = ack_cnt;
`ifdef SD_RESP_BOUNDS_EN
        pushRead(32'h5A000, 1, 512, 512);
        applyStimulus(1'b1, 1'b0, 32'd720, 0);
        waitAck(1'b0, 4000, "t4_oob_ack_fall");
        checkCounts("t4_oob", bw0, mr0, mw0, ak0, 512, 0, 0, 1024);
`else
        pushRead(32'h5A000, 0, 512, 512);
        applyStimulus(1'b1, 1'b0, 32'd720, 0);
        waitAck(1'b0, 4000, "t4_720_ack_fall");
        checkCounts("t4_720", bw0, mr0, mw0, ak0, 512, 512, 0, 2048);
`endif
        bw0 = buff_wr_cnt; mr0 = mem_rd_cnt; mw0 = mem_wr_cnt; ak0 = ack_cnt;
        pushRead(32'h59E00, 0, 512, 512);
        applyStimulus(1'b1, 1'b0, 32'd719, 0);
        waitAck(1'b0, 4000, "t4_719_ack_fall");
        checkCounts("t4_719", bw0, mr0, mw0, ak0, 512, 512, 0, 2048);

        $display("[TB] test 5: rd and wr together, reset at index 100");
        bw0 = buff_wr_cnt; mr0 = mem_rd_cnt; mw0 = mem_wr_cnt; ak0 = ack_cnt;
        pushRead(32'h600, 0, 100, 101);
        applyStimulus(1'b1, 1'b1, 32'd3, 0);
        n = 0;
        while (sd_buff_addr !== 9'd100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_reached_index", {55'b0, sd_buff_addr}, 64'd100);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_ack_after_reset", {63'b0, sd_ack}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkCounts("t5", bw0, mr0, mw0, ak0, 100, 101, 0, -1);

        $display("[TB] test 6: request held through DONE");
        bw0 = buff_wr_cnt; mr0 = mem_rd_cnt; mw0 = mem_wr_cnt; ak0 = ack_cnt;
        pushRead(32'h800, 0, 512, 512);
        pushRead(32'hA00, 0, 512, 512);
        applyStimulus(1'b1, 1'b0, 32'd4, 1);
        sd_lba = 32'd5;
        waitAck(1'b0, 4000, "t6_first_ack_fall");
        @(negedge clk);
        checkOutput("t6_idle_gap", {63'b0, sd_ack}, 64'd0);
        @(negedge clk);
        checkOutput("t6_restart", {63'b0, sd_ack}, 64'd1);
        sd_rd = 1'b0;
        waitAck(1'b0, 4000, "t6_second_ack_fall");
        checkCounts("t6", bw0, mr0, mw0, ak0, 1024, 1024, 0, 4096);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
